mem_arbiter: RTL and testbench

Shares the single processor–memory port between the instruction-cache controller and the data cache. It picks one requester per cycle and forwards that requester's command to memory. It records which requester owns each accepted load tag, so returning data is steered back to the right cache. It sits between both cache controllers and the memory model. It adds no latency on the request or return path.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_tag_table.sv | 73 +++++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared bus command, tag and owner encodings for mem_arbiter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int TAG_W_DEFAULT = 4;

  localparam logic OWNER_D = 1'b0;
  localparam logic OWNER_I = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_tag_table.sv
// ============================================================================
// mem_tag_table : per-tag owner table with allocate/return/lookup, occupancy
//                 count and sticky tag-collision flag
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             ret_hit,
  output logic             ret_owner,
  output logic [4:0]       outstanding,
  output logic             protocol_err
);

  localparam int DEPTH = 2 ** TAG_W;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_owner;
  logic             r_protocol_err;
  logic             w_ret_hit;
  logic             w_collision;
  logic [4:0]       w_count;

  assign w_ret_hit = (ret_tag != '0) && r_valid[ret_tag];
  assign ret_hit   = w_ret_hit;
  assign ret_owner = r_owner[ret_tag];

  // A tag freed by this cycle's return may be handed out again without error.
  assign w_collision = alloc_en && r_valid[alloc_tag] &&
                       !(w_ret_hit && (ret_tag == alloc_tag));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid        <= '0;
      r_owner        <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_ret_hit) begin
        r_valid[ret_tag] <= 1'b0;
      end
      if (alloc_en) begin
        r_valid[alloc_tag] <= 1'b1;
        r_owner[alloc_tag] <= alloc_owner;
      end
      if (w_collision) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_count = w_count + 5'(r_valid[i]);
    end
  end

  assign outstanding  = w_count;
  assign protocol_err = r_protocol_err;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : dcache/icache arbiter for the shared memory port with
//               starvation override and tag-based return steering
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_W        = TAG_W_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       dcache2arb_command,
  input  logic [63:0]      dcache2arb_addr,
  input  logic [63:0]      dcache2arb_data,
  input  logic [1:0]       icache2arb_command,
  input  logic [63:0]      icache2arb_addr,
  input  logic [TAG_W-1:0] mem2arb_response,
  input  logic [TAG_W-1:0] mem2arb_tag,
  input  logic [63:0]      mem2arb_data,
  output logic [1:0]       arb2mem_command,
  output logic [63:0]      arb2mem_addr,
  output logic [63:0]      arb2mem_data,
  output logic [TAG_W-1:0] arb2dcache_response,
  output logic [TAG_W-1:0] arb2icache_response,
  output logic [TAG_W-1:0] arb2dcache_tag,
  output logic [TAG_W-1:0] arb2icache_tag,
  output logic [63:0]      arb2proc_data,
  output logic [4:0]       outstanding,
  output logic             protocol_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_d_req;
  logic             w_i_req;
  logic             w_starved;
  logic             w_grant_d;
  logic             w_grant_i;
  logic             w_alloc_en;
  logic             w_ret_hit;
  logic             w_ret_owner;
  logic [4:0]       w_outstanding;
  logic             w_protocol_err;

  assign w_d_req   = (dcache2arb_command != BUS_NONE);
  assign w_i_req   = (icache2arb_command == BUS_LOAD);
  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_grant_i = w_i_req && (!w_d_req || w_starved);
  assign w_grant_d = w_d_req && !w_grant_i;

  // Only loads need steering back, so stores never occupy a tag.
  assign w_alloc_en = !reset && (mem2arb_response != '0) &&
                      ((w_grant_d && (dcache2arb_command == BUS_LOAD)) || w_grant_i);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_i_req && !w_grant_i) begin
      if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  mem_tag_table #(
    .TAG_W(TAG_W)
  ) u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (w_alloc_en),
    .alloc_tag    (mem2arb_response),
    .alloc_owner  (w_grant_i ? OWNER_I : OWNER_D),
    .ret_tag      (mem2arb_tag),
    .ret_hit      (w_ret_hit),
    .ret_owner    (w_ret_owner),
    .outstanding  (w_outstanding),
    .protocol_err (w_protocol_err)
  );

  always_comb begin
    arb2mem_command     = BUS_NONE;
    arb2mem_addr        = '0;
    arb2mem_data        = '0;
    arb2dcache_response = '0;
    arb2icache_response = '0;
    arb2dcache_tag      = '0;
    arb2icache_tag      = '0;
    arb2proc_data       = '0;
    outstanding         = '0;
    protocol_err        = 1'b0;
    if (!reset) begin
      if (w_grant_d) begin
        arb2mem_command     = dcache2arb_command;
        arb2mem_addr        = dcache2arb_addr;
        arb2mem_data        = (dcache2arb_command == BUS_STORE) ? dcache2arb_data : '0;
        arb2dcache_response = mem2arb_response;
      end else if (w_grant_i) begin
        arb2mem_command     = BUS_LOAD;
        arb2mem_addr        = icache2arb_addr;
        arb2icache_response = mem2arb_response;
      end
      if (w_ret_hit) begin
        if (w_ret_owner == OWNER_I) begin
          arb2icache_tag = mem2arb_tag;
        end else begin
          arb2dcache_tag = mem2arb_tag;
        end
      end
      arb2proc_data = mem2arb_data;
      outstanding   = w_outstanding;
      protocol_err  = w_protocol_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  dcache2arb_command;
  logic [63:0] dcache2arb_addr;
  logic [63:0] dcache2arb_data;
  logic [1:0]  icache2arb_command;
  logic [63:0] icache2arb_addr;
  logic [3:0]  mem2arb_response;
  logic [3:0]  mem2arb_tag;
  logic [63:0] mem2arb_data;
  logic [1:0]  arb2mem_command;
  logic [63:0] arb2mem_addr;
  logic [63:0] arb2mem_data;
  logic [3:0]  arb2dcache_response;
  logic [3:0]  arb2icache_response;
  logic [3:0]  arb2dcache_tag;
  logic [3:0]  arb2icache_tag;
  logic [63:0] arb2proc_data;
  logic [4:0]  outstanding;
  logic        protocol_err;

  int checks;
  int failures;

  mem_arbiter #(
    .TAG_W(4),
    .STARVE_LIMIT(4)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .dcache2arb_command  (dcache2arb_command),
    .dcache2arb_addr     (dcache2arb_addr),
    .dcache2arb_data     (dcache2arb_data),
    .icache2arb_command  (icache2arb_command),
    .icache2arb_addr     (icache2arb_addr),
    .mem2arb_response    (mem2arb_response),
    .mem2arb_tag         (mem2arb_tag),
    .mem2arb_data        (mem2arb_data),
    .arb2mem_command     (arb2mem_command),
    .arb2mem_addr        (arb2mem_addr),
    .arb2mem_data        (arb2mem_data),
    .arb2dcache_response (arb2dcache_response),
    .arb2icache_response (arb2icache_response),
    .arb2dcache_tag      (arb2dcache_tag),
    .arb2icache_tag      (arb2icache_tag),
    .arb2proc_data       (arb2proc_data),
    .outstanding         (outstanding),
    .protocol_err        (protocol_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs change 1ns after the rising edge; checks run 1ns after that.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dcache2arb_command = BUS_NONE;
    dcache2arb_addr    = '0;
    dcache2arb_data    = '0;
    icache2arb_command = BUS_NONE;
    icache2arb_addr    = '0;
    mem2arb_response   = '0;
    mem2arb_tag        = '0;
    mem2arb_data       = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    dcache2arb_command = BUS_LOAD;
    dcache2arb_addr    = 64'h40;
    mem2arb_response   = 4'd3;
    mem2arb_tag        = 4'd3;
    mem2arb_data       = 64'h1234;
    #1;
    checks++;
    if (arb2mem_command !== BUS_NONE || arb2mem_addr !== 64'h0 || arb2dcache_response !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs cmd=%0d addr=%h dresp=%0d expected 0/0/0", arb2mem_command, arb2mem_addr, arb2dcache_response);
    end
    step();
    step();
    checks++;
    if (outstanding !== 5'd0 || protocol_err !== 1'b0 || arb2dcache_tag !== 4'd0 || arb2proc_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_state out=%0d err=%0d dtag=%0d data=%h expected 0", outstanding, protocol_err, arb2dcache_tag, arb2proc_data);
    end
    reset = 1'b0;
    idle();
    step();
    checks++;
    if (outstanding !== 5'd0) begin
      failures++;
      $display("FAIL reset_no_alloc outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_dcache_only();
    dcache2arb_command = BUS_LOAD;
    dcache2arb_addr    = 64'h1000;
    dcache2arb_data    = 64'hFFFF;
    mem2arb_response   = 4'd3;
    #1;
    checks++;
    if (arb2mem_command !== BUS_LOAD || arb2mem_addr !== 64'h1000 || arb2mem_data !== 64'h0) begin
      failures++;
      $display("FAIL dload_forward cmd=%0d addr=%h data=%h expected 1/1000/0", arb2mem_command, arb2mem_addr, arb2mem_data);
    end
    checks++;
    if (arb2dcache_response !== 4'd3 || arb2icache_response !== 4'd0) begin
      failures++;
      $display("FAIL dload_response d=%0d i=%0d expected 3/0", arb2dcache_response, arb2icache_response);
    end
    step();
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd1) begin
      failures++;
      $display("FAIL dload_outstanding got=%0d expected 1", outstanding);
    end
    step();
    step();
    step();
    mem2arb_tag  = 4'd3;
    mem2arb_data = 64'hDEAD;
    #1;
    checks++;
    if (arb2dcache_tag !== 4'd3 || arb2icache_tag !== 4'd0 || arb2proc_data !== 64'hDEAD) begin
      failures++;
      $display("FAIL dload_return dtag=%0d itag=%0d data=%h expected 3/0/dead", arb2dcache_tag, arb2icache_tag, arb2proc_data);
    end
    step();
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd0) begin
      failures++;
      $display("FAIL dload_retire outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_starvation();
    logic exp_i;
    for (int c = 0; c < 10; c++) begin
      dcache2arb_command = BUS_STORE;
      dcache2arb_addr    = 64'h5000 + 64'(c);
      dcache2arb_data    = 64'hA0 + 64'(c);
      icache2arb_command = BUS_LOAD;
      icache2arb_addr    = 64'h9000;
      mem2arb_response   = 4'(c + 1);
      exp_i = (c == 4) || (c == 9);
      #1;
      checks++;
      if (exp_i) begin
        if (arb2mem_command !== BUS_LOAD || arb2mem_addr !== 64'h9000 || arb2mem_data !== 64'h0 ||
            arb2icache_response !== 4'(c + 1) || arb2dcache_response !== 4'd0) begin
          failures++;
          $display("FAIL starve_cycle%0d cmd=%0d addr=%h iresp=%0d dresp=%0d expected icache grant", c,
                   arb2mem_command, arb2mem_addr, arb2icache_response, arb2dcache_response);
        end
      end else begin
        if (arb2mem_command !== BUS_STORE || arb2mem_addr !== 64'h5000 + 64'(c) ||
            arb2mem_data !== 64'hA0 + 64'(c) || arb2dcache_response !== 4'(c + 1) ||
            arb2icache_response !== 4'd0) begin
          failures++;
          $display("FAIL starve_cycle%0d cmd=%0d addr=%h dresp=%0d iresp=%0d expected dcache grant", c,
                   arb2mem_command, arb2mem_addr, arb2dcache_response, arb2icache_response);
        end
      end
      step();
    end
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd2) begin
      failures++;
      $display("FAIL starve_outstanding got=%0d expected 2", outstanding);
    end
    mem2arb_tag = 4'd5;
    #1;
    checks++;
    if (arb2icache_tag !== 4'd5 || arb2dcache_tag !== 4'd0) begin
      failures++;
      $display("FAIL starve_return5 itag=%0d dtag=%0d expected 5/0", arb2icache_tag, arb2dcache_tag);
    end
    step();
    mem2arb_tag = 4'd10;
    #1;
    checks++;
    if (arb2icache_tag !== 4'd10 || arb2dcache_tag !== 4'd0) begin
      failures++;
      $display("FAIL starve_return10 itag=%0d dtag=%0d expected 10/0", arb2icache_tag, arb2dcache_tag);
    end
    step();
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd0) begin
      failures++;
      $display("FAIL starve_retire outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_store_drop();
    dcache2arb_command = BUS_STORE;
    dcache2arb_addr    = 64'h2000;
    dcache2arb_data    = 64'h55;
    mem2arb_response   = 4'd7;
    #1;
    checks++;
    if (arb2mem_command !== BUS_STORE || arb2mem_addr !== 64'h2000 || arb2mem_data !== 64'h55 ||
        arb2dcache_response !== 4'd7) begin
      failures++;
      $display("FAIL store_forward cmd=%0d addr=%h data=%h dresp=%0d expected 2/2000/55/7",
               arb2mem_command, arb2mem_addr, arb2mem_data, arb2dcache_response);
    end
    step();
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd0) begin
      failures++;
      $display("FAIL store_no_entry outstanding=%0d expected 0", outstanding);
    end
    step();
    mem2arb_tag  = 4'd7;
    mem2arb_data = 64'hBEEF;
    #1;
    checks++;
    if (arb2dcache_tag !== 4'd0 || arb2icache_tag !== 4'd0) begin
      failures++;
      $display("FAIL store_drop dtag=%0d itag=%0d expected 0/0", arb2dcache_tag, arb2icache_tag);
    end
    step();
    idle();
    #1;
    checks++;
    if (protocol_err !== 1'b0 || outstanding !== 5'd0) begin
      failures++;
      $display("FAIL store_drop_err err=%0d out=%0d expected 0/0", protocol_err, outstanding);
    end
  endtask

  task automatic test_rejection();
    icache2arb_command = BUS_LOAD;
    icache2arb_addr    = 64'h3000;
    for (int c = 0; c < 4; c++) begin
      mem2arb_response = (c == 3) ? 4'd9 : 4'd0;
      #1;
      checks++;
      if (arb2mem_command !== BUS_LOAD || arb2mem_addr !== 64'h3000 ||
          arb2icache_response !== mem2arb_response || arb2dcache_response !== 4'd0) begin
        failures++;
        $display("FAIL reject_cycle%0d cmd=%0d addr=%h iresp=%0d dresp=%0d expected 1/3000/%0d/0", c,
                 arb2mem_command, arb2mem_addr, arb2icache_response, arb2dcache_response, mem2arb_response);
      end
      step();
    end
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd1) begin
      failures++;
      $display("FAIL reject_outstanding got=%0d expected 1", outstanding);
    end
    mem2arb_tag = 4'd9;
    #1;
    checks++;
    if (arb2icache_tag !== 4'd9 || arb2dcache_tag !== 4'd0) begin
      failures++;
      $display("FAIL reject_return itag=%0d dtag=%0d expected 9/0", arb2icache_tag, arb2dcache_tag);
    end
    step();
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd0) begin
      failures++;
      $display("FAIL reject_retire outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_same_cycle_and_collision();
    dcache2arb_command = BUS_LOAD;
    dcache2arb_addr    = 64'h100;
    mem2arb_response   = 4'd2;
    step();
    idle();
    icache2arb_command = BUS_LOAD;
    icache2arb_addr    = 64'h200;
    mem2arb_response   = 4'd2;
    mem2arb_tag        = 4'd2;
    #1;
    checks++;
    if (arb2dcache_tag !== 4'd2 || arb2icache_tag !== 4'd0 || arb2icache_response !== 4'd2) begin
      failures++;
      $display("FAIL realloc_return dtag=%0d itag=%0d iresp=%0d expected 2/0/2", arb2dcache_tag, arb2icache_tag, arb2icache_response);
    end
    step();
    idle();
    #1;
    checks++;
    if (protocol_err !== 1'b0 || outstanding !== 5'd1) begin
      failures++;
      $display("FAIL realloc_noerr err=%0d out=%0d expected 0/1", protocol_err, outstanding);
    end
    mem2arb_tag = 4'd2;
    #1;
    checks++;
    if (arb2icache_tag !== 4'd2 || arb2dcache_tag !== 4'd0) begin
      failures++;
      $display("FAIL realloc_owner itag=%0d dtag=%0d expected 2/0", arb2icache_tag, arb2dcache_tag);
    end
    step();
    idle();
    dcache2arb_command = BUS_LOAD;
    mem2arb_response   = 4'd5;
    step();
    idle();
    icache2arb_command = BUS_LOAD;
    mem2arb_response   = 4'd5;
    step();
    idle();
    #1;
    checks++;
    if (protocol_err !== 1'b1 || outstanding !== 5'd1) begin
      failures++;
      $display("FAIL collision_set err=%0d out=%0d expected 1/1", protocol_err, outstanding);
    end
    step();
    step();
    mem2arb_tag = 4'd5;
    #1;
    checks++;
    if (arb2icache_tag !== 4'd5 || arb2dcache_tag !== 4'd0) begin
      failures++;
      $display("FAIL collision_overwrite itag=%0d dtag=%0d expected 5/0", arb2icache_tag, arb2dcache_tag);
    end
    step();
    idle();
    #1;
    checks++;
    if (protocol_err !== 1'b1 || outstanding !== 5'd0) begin
      failures++;
      $display("FAIL collision_sticky err=%0d out=%0d expected 1/0", protocol_err, outstanding);
    end
  endtask

  task automatic test_reset_inflight();
    dcache2arb_command = BUS_LOAD;
    mem2arb_response   = 4'd1;
    step();
    idle();
    icache2arb_command = BUS_LOAD;
    mem2arb_response   = 4'd4;
    step();
    idle();
    dcache2arb_command = BUS_LOAD;
    mem2arb_response   = 4'd6;
    step();
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd3) begin
      failures++;
      $display("FAIL inflight_count got=%0d expected 3", outstanding);
    end
    reset       = 1'b1;
    mem2arb_tag = 4'd4;
    #1;
    checks++;
    if (arb2icache_tag !== 4'd0 || outstanding !== 5'd0 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL inflight_during_reset itag=%0d out=%0d err=%0d expected 0/0/0", arb2icache_tag, outstanding, protocol_err);
    end
    step();
    step();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (outstanding !== 5'd0 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL inflight_after_reset out=%0d err=%0d expected 0/0", outstanding, protocol_err);
    end
    for (int k = 0; k < 3; k++) begin
      mem2arb_tag = (k == 0) ? 4'd1 : (k == 1) ? 4'd4 : 4'd6;
      #1;
      checks++;
      if (arb2dcache_tag !== 4'd0 || arb2icache_tag !== 4'd0) begin
        failures++;
        $display("FAIL stale_return tag=%0d dtag=%0d itag=%0d expected 0/0", mem2arb_tag, arb2dcache_tag, arb2icache_tag);
      end
      step();
    end
    idle();
    #1;
    checks++;
    if (protocol_err !== 1'b0 || outstanding !== 5'd0) begin
      failures++;
      $display("FAIL stale_quiet err=%0d out=%0d expected 0/0", protocol_err, outstanding);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    test_reset();
    test_dcache_only();
    test_starvation();
    test_store_drop();
    test_rejection();
    test_same_cycle_and_collision();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
